// File: rtl/caliptra_prim_cipher_pkg.sv
// PRESENT cipher primitives: 4-bit S-box tables, bit permutation, and the forward and
// inverse key schedules for 64/80/128-bit keys, plus a width-dispatching key-step helper.
package caliptra_prim_cipher_pkg;

    localparam logic [15:0][3:0] PRESENT_SBOX4 = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC};
    localparam logic [15:0][3:0] PRESENT_SBOX4_INV = {
        4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
        4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5};

    function automatic logic [63:0] present_sbox(logic [63:0] s, int unsigned dw, logic inv);
        logic [63:0] o;
        o = s;
        for (int unsigned n = 0; n < 16; n++) begin
            if (n < dw / 4) o[4*n +: 4] = inv ? PRESENT_SBOX4_INV[s[4*n +: 4]] : PRESENT_SBOX4[s[4*n +: 4]];
        end
        return o;
    endfunction

    // Bit i moves to i*(dw/4) mod (dw-1); the top bit is a fixed point.
    function automatic logic [63:0] present_perm(logic [63:0] s, int unsigned dw, logic inv);
        logic [63:0] o;
        int unsigned d;
        o = s;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < dw) begin
                d = (i == dw - 1) ? i : (i * (dw / 4)) % (dw - 1);
                if (inv) o[i] = s[d];
                else     o[d] = s[i];
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] present_update_key64(logic [63:0] k, logic [4:0] idx);
        logic [63:0] o;
        o = {k[2:0], k[63:3]};
        o[63:60] = PRESENT_SBOX4[o[63:60]];
        o[19:15] = o[19:15] ^ idx;
        return o;
    endfunction

    function automatic logic [63:0] present_inv_update_key64(logic [63:0] k, logic [4:0] idx);
        logic [63:0] o;
        o = k;
        o[19:15] = o[19:15] ^ idx;
        o[63:60] = PRESENT_SBOX4_INV[o[63:60]];
        return {o[60:0], o[63:61]};
    endfunction

    function automatic logic [79:0] present_update_key80(logic [79:0] k, logic [4:0] idx);
        logic [79:0] o;
        o = {k[18:0], k[79:19]};
        o[79:76] = PRESENT_SBOX4[o[79:76]];
        o[19:15] = o[19:15] ^ idx;
        return o;
    endfunction

    function automatic logic [79:0] present_inv_update_key80(logic [79:0] k, logic [4:0] idx);
        logic [79:0] o;
        o = k;
        o[19:15] = o[19:15] ^ idx;
        o[79:76] = PRESENT_SBOX4_INV[o[79:76]];
        return {o[60:0], o[79:61]};
    endfunction

    function automatic logic [127:0] present_update_key128(logic [127:0] k, logic [4:0] idx);
        logic [127:0] o;
        o = {k[66:0], k[127:67]};
        o[127:124] = PRESENT_SBOX4[o[127:124]];
        o[123:120] = PRESENT_SBOX4[o[123:120]];
        o[66:62]   = o[66:62] ^ idx;
        return o;
    endfunction

    function automatic logic [127:0] present_inv_update_key128(logic [127:0] k, logic [4:0] idx);
        logic [127:0] o;
        o = k;
        o[66:62]   = o[66:62] ^ idx;
        o[127:124] = PRESENT_SBOX4_INV[o[127:124]];
        o[123:120] = PRESENT_SBOX4_INV[o[123:120]];
        return {o[60:0], o[127:61]};
    endfunction

    // Keys travel zero-extended to 128 bits so callers stay width-agnostic.
    function automatic logic [127:0] present_key_step(logic [127:0] k, int unsigned kw,
                                                     logic [4:0] idx, logic inv);
        case (kw)
            64:      return inv ? 128'(present_inv_update_key64(k[63:0], idx))
                                : 128'(present_update_key64(k[63:0], idx));
            80:      return inv ? 128'(present_inv_update_key80(k[79:0], idx))
                                : 128'(present_update_key80(k[79:0], idx));
            default: return inv ? present_inv_update_key128(k, idx) : present_update_key128(k, idx);
        endcase
    endfunction

endpackage

// File: rtl/caliptra_prim_present_dec_iter_pkg.sv
// Local types for the iterative PRESENT decryption engine.
package caliptra_prim_present_dec_iter_pkg;

    localparam int unsigned IdxWidth = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2,
        DONE   = 2'd3
    } dec_state_e;

endpackage

// File: rtl/caliptra_prim_present.sv
// Combinational PRESENT round datapath: NumPhysRounds rounds in either direction.
// Rounds exclude the final key whitening, which the caller applies.
module caliptra_prim_present
    import caliptra_prim_cipher_pkg::*;
#(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned KeyWidth      = 128,
    parameter int unsigned NumPhysRounds = 1,
    parameter bit          Decrypt       = 1'b1
) (
    input  logic [DataWidth-1:0] data_i,
    input  logic [KeyWidth-1:0]  key_i,
    input  logic [4:0]           idx_i,
    output logic [DataWidth-1:0] data_o,
    output logic [KeyWidth-1:0]  key_o
);

    always_comb begin
        logic [63:0]  s;
        logic [127:0] k;
        logic [4:0]   idx;
        s   = 64'(data_i);
        k   = 128'(key_i);
        idx = idx_i;
        for (int r = 0; r < int'(NumPhysRounds); r++) begin
            if (Decrypt) begin
                s   = present_sbox(present_perm(s ^ 64'(k[KeyWidth-1 -: DataWidth]), DataWidth, 1'b1),
                                   DataWidth, 1'b1);
                k   = present_key_step(k, KeyWidth, idx, 1'b1);
                idx = idx - 5'd1;
            end else begin
                s   = present_perm(present_sbox(s ^ 64'(k[KeyWidth-1 -: DataWidth]), DataWidth, 1'b0),
                                   DataWidth, 1'b0);
                k   = present_key_step(k, KeyWidth, idx, 1'b0);
                idx = idx + 5'd1;
            end
        end
        data_o = s[DataWidth-1:0];
        key_o  = k[KeyWidth-1:0];
    end

endmodule

// File: rtl/caliptra_prim_present_dec_iter.sv
// Iterative PRESENT decryption: expands the key forward, then runs one inverse round per cycle.
// Define CALIPTRA_PRIM_PRESENT_DEC_KEYCACHE_EN to cache the last expanded key and skip KEYEXP on reuse.
module caliptra_prim_present_dec_iter
    import caliptra_prim_cipher_pkg::*;
    import caliptra_prim_present_dec_iter_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned KeyWidth  = 128,
    parameter int unsigned NumRounds = 31
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic [KeyWidth-1:0]  key_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] data_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRounds);

    dec_state_e           state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d, round_data;
    logic [KeyWidth-1:0]  key_q, key_d, round_key, key_fwd, cache_exp;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [127:0]         key_fwd_full;
    logic                 cache_hit;

    caliptra_prim_present #(
        .DataWidth    (DataWidth),
        .KeyWidth     (KeyWidth),
        .NumPhysRounds(1),
        .Decrypt      (1'b1)
    ) u_round (
        .data_i(data_q),
        .key_i (key_q),
        .idx_i (idx_q),
        .data_o(round_data),
        .key_o (round_key)
    );

    assign key_fwd_full = present_key_step(128'(key_q), KeyWidth, idx_q, 1'b0);
    assign key_fwd      = key_fwd_full[KeyWidth-1:0];

`ifdef CALIPTRA_PRIM_PRESENT_DEC_KEYCACHE_EN
    logic                cache_valid_q;
    logic [KeyWidth-1:0] cache_key_q, cache_exp_q;

    assign cache_hit = cache_valid_q && (key_i == cache_key_q);
    assign cache_exp = cache_exp_q;

    // The tag is taken at accept; no lookup can happen before KEYEXP finishes and refreshes the
    // expansion, and only reset can abort KEYEXP, which also drops the valid bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: cache words are reset too; only valid matters, but this keeps every flop deterministic.
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_exp_q   <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i && !cache_hit) cache_key_q <= key_i;
            if (state_q == KEYEXP && idx_q == LastIdx) begin
                cache_exp_q   <= key_fwd;
                cache_valid_q <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_exp = '0;
`endif

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    data_d = data_i;
                    if (cache_hit) begin
                        key_d   = cache_exp;
                        idx_d   = LastIdx;
                        state_d = DEC;
                    end else begin
                        key_d   = key_i;
                        idx_d   = 5'd1;
                        state_d = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                key_d = key_fwd;
                if (idx_q == LastIdx) state_d = DEC;
                else                  idx_d   = idx_q + 5'd1;
            end
            DEC: begin
                key_d = round_key;
                idx_d = idx_q - 5'd1;
                if (idx_q == 5'd1) begin
                    data_d  = round_data ^ round_key[KeyWidth-1 -: DataWidth];
                    state_d = DONE;
                end else begin
                    data_d = round_data;
                end
            end
            DONE: begin
                // Scrub the working registers so no key material lingers between requests.
                if (rsp_ready_i) begin
                    data_d  = '0;
                    key_d   = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign data_o      = (state_q == DONE) ? data_q : '0;

    assert property (@(posedge clk_i)
        (DataWidth == 64 && (KeyWidth == 64 || KeyWidth == 80 || KeyWidth == 128)) ||
        (DataWidth == 32 && KeyWidth == 64));
    assert property (@(posedge clk_i) NumRounds >= 1 && NumRounds <= 31);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(data_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !rsp_valid_o |-> data_o == '0);

endmodule

// File: tb/tb_caliptra_prim_present_dec_iter.sv
// Directed bench: three engines (KW80/R31, KW128/R31, KW128/R8) checked against known answers
// and a forward-only reference encryptor, including stall, reset and key-cache latency cases.
`timescale 1ns/1ps
module tb_caliptra_prim_present_dec_iter;

    localparam int NumDut = 3;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
`ifdef CALIPTRA_PRIM_PRESENT_DEC_KEYCACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [63:0]  ct_v  [NumDut];
    logic [63:0]  exp_v [NumDut];
    logic [127:0] key_v [NumDut];
    logic         rdy   [NumDut];
    logic         vld   [NumDut];
    logic [63:0]  dout  [NumDut];
    logic [127:0] cache_key [NumDut];
    bit           cache_ok  [NumDut];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    caliptra_prim_present_dec_iter #(.DataWidth(64), .KeyWidth(80), .NumRounds(31)) u_dut80 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
        .data_i(ct_v[0]), .key_i(key_v[0][79:0]), .rsp_valid_o(vld[0]),
        .rsp_ready_i(rsp_ready), .data_o(dout[0]));
    caliptra_prim_present_dec_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(31)) u_dut128 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
        .data_i(ct_v[1]), .key_i(key_v[1]), .rsp_valid_o(vld[1]),
        .rsp_ready_i(rsp_ready), .data_o(dout[1]));
    caliptra_prim_present_dec_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
        .data_i(ct_v[2]), .key_i(key_v[2]), .rsp_valid_o(vld[2]),
        .rsp_ready_i(rsp_ready), .data_o(dout[2]));

    function automatic int nr(input int i);
        return (i == 2) ? 8 : 31;
    endfunction

    function automatic int kw(input int i);
        return (i == 0) ? 80 : 128;
    endfunction

    // Straightforward forward PRESENT encryption used as the reference.
    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key,
                                            input int kwid, input int rounds);
        logic [63:0]  s, t;
        logic [127:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= rounds; r++) begin
            s = s ^ ((kwid == 80) ? k[79:16] : k[127:64]);
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
            t = '0;
            for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
            t[63] = s[63];
            s = t;
            if (kwid == 80) begin
                k[79:0]   = {k[18:0], k[79:19]};
                k[79:76]  = SBOX[k[79:76]];
                k[19:15]  = k[19:15] ^ 5'(r);
            end else begin
                k          = {k[66:0], k[127:67]};
                k[127:124] = SBOX[k[127:124]];
                k[123:120] = SBOX[k[123:120]];
                k[66:62]   = k[66:62] ^ 5'(r);
            end
        end
        return s ^ ((kwid == 80) ? k[79:16] : k[127:64]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < NumDut; i++) begin
            key_v[i] = {$urandom, $urandom, $urandom, $urandom};
            if (kw(i) == 80) key_v[i][127:80] = '0;
            exp_v[i] = {$urandom, $urandom};
            ct_v[i]  = ref_enc(exp_v[i], key_v[i], kw(i), nr(i));
        end
    endtask

    task automatic load_same_key();
        for (int i = 0; i < NumDut; i++) begin
            exp_v[i] = {$urandom, $urandom};
            ct_v[i]  = ref_enc(exp_v[i], key_v[i], kw(i), nr(i));
        end
    endtask

    task automatic clear_cache_model();
        for (int i = 0; i < NumDut; i++) cache_ok[i] = 1'b0;
    endtask

    // Issues one request to all engines and checks latency and plaintext; ends on a negedge.
    task automatic start_and_wait(input string tag);
        int lat [NumDut];
        int exp_lat [NumDut];
        int cyc;
        for (int i = 0; i < NumDut; i++) begin
            lat[i]     = 0;
            exp_lat[i] = 2 * nr(i) + 1;
            if (CacheEn && cache_ok[i] && cache_key[i] == key_v[i]) exp_lat[i] = nr(i) + 1;
            else if (CacheEn) begin
                cache_ok[i]  = 1'b1;
                cache_key[i] = key_v[i];
            end
        end
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && cyc < 200) begin
            for (int i = 0; i < NumDut; i++) if (vld[i] && lat[i] == 0) lat[i] = cyc;
            if (lat[0] == 0 || lat[1] == 0 || lat[2] == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        for (int i = 0; i < NumDut; i++) begin
            chk($sformatf("%s.lat%0d", tag, i), 64'(lat[i]), 64'(exp_lat[i]));
            chk($sformatf("%s.pt%0d", tag, i), dout[i], exp_v[i]);
        end
    endtask

    task automatic accept_and_check(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < NumDut; i++) begin
            chk($sformatf("%s.post_vld%0d", tag, i), 64'(vld[i]), 64'd0);
            chk($sformatf("%s.post_data%0d", tag, i), dout[i], 64'd0);
            chk($sformatf("%s.post_rdy%0d", tag, i), 64'(rdy[i]), 64'd1);
        end
    endtask

    task automatic run_txn(input string tag);
        start_and_wait(tag);
        accept_and_check(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NumDut; i++) begin
            ct_v[i]      = '0;
            exp_v[i]     = '0;
            key_v[i]     = '0;
            cache_key[i] = '0;
        end
        clear_cache_model();

        repeat (2) @(negedge clk);
        for (int i = 0; i < NumDut; i++) begin
            chk($sformatf("reset.rdy%0d", i), 64'(rdy[i]), 64'd1);
            chk($sformatf("reset.vld%0d", i), 64'(vld[i]), 64'd0);
            chk($sformatf("reset.data%0d", i), dout[i], 64'd0);
        end
        rst_n = 1'b1;

        // Published PRESENT-80 answers on the 80-bit engine; the others get model vectors.
        load_random();
        key_v[0] = '0;
        ct_v[0]  = 64'h5579c1387b228445;
        exp_v[0] = 64'h0000000000000000;
        run_txn("kat_zero");

        load_random();
        key_v[0] = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
        ct_v[0]  = 64'h3333dcd3213210d2;
        exp_v[0] = 64'hFFFFFFFFFFFFFFFF;
        run_txn("kat_ones");

        repeat (100) begin
            load_random();
            run_txn("rand");
        end

        // Consumer stalls 20 cycles while a competing request is offered.
        load_random();
        start_and_wait("stall");
        for (int c = 0; c < 20; c++) begin
            req_valid = 1'b1;
            for (int i = 0; i < NumDut; i++) ct_v[i] = ct_v[i] ^ 64'(c + 1);
            @(negedge clk);
            for (int i = 0; i < NumDut; i++) begin
                chk($sformatf("stall.vld%0d", i), 64'(vld[i]), 64'd1);
                chk($sformatf("stall.data%0d", i), dout[i], exp_v[i]);
                chk($sformatf("stall.rdy%0d", i), 64'(rdy[i]), 64'd0);
            end
        end
        req_valid = 1'b0;
        accept_and_check("stall");
        repeat (3) begin
            @(negedge clk);
            chk("stall.idle_rdy", 64'(rdy[0]), 64'd1);
            chk("stall.idle_vld", 64'(vld[0]), 64'd0);
        end

        // Reset while the 31-round engines are mid-DEC.
        load_random();
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (36) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NumDut; i++) begin
            chk($sformatf("mid_rst.rdy%0d", i), 64'(rdy[i]), 64'd1);
            chk($sformatf("mid_rst.vld%0d", i), 64'(vld[i]), 64'd0);
            chk($sformatf("mid_rst.data%0d", i), dout[i], 64'd0);
        end
        clear_cache_model();
        @(negedge clk);
        rst_n = 1'b1;
        load_random();
        run_txn("post_rst");

        // Key reuse, key change, and reuse across a reset.
        load_same_key();
        run_txn("same_key");
        load_random();
        run_txn("new_key");
        load_same_key();
        run_txn("same_key2");
        @(negedge clk);
        rst_n = 1'b0;
        clear_cache_model();
        @(negedge clk);
        rst_n = 1'b1;
        load_same_key();
        run_txn("key_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
